// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmitter.
// Build option: UART_SYNC_HEADER_EN adds a 0xA5 sync byte per word.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_e;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;
  localparam int BITS_PER_BYTE = 8;
  localparam int BYTES_PER_WORD = 4;

`ifdef UART_SYNC_HEADER_EN
  localparam int FRAME_BYTES = BYTES_PER_WORD + 1;
`else
  localparam int FRAME_BYTES = BYTES_PER_WORD;
`endif

endpackage

// File: rtl/uart_word_tx_byte.sv
// uart_byte_tx: 8N1 byte serialiser with baud counter.
// Ports: clk, rst (sync, active-low), byte_valid_i/byte_data_i in,
//   byte_done_o (last stop-bit cycle), tx_o (registered line).
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_done_o,
  output logic       tx_o
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q;
  logic          wrap;

  assign wrap        = (baud_q == BAUD_MAX);
  // A new byte offered in this cycle starts with no idle gap.
  assign byte_done_o = (state_q == STOP) && wrap;
  assign tx_o        = tx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q != IDLE)
        baud_q <= wrap ? '0 : baud_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (byte_valid_i) begin
            sh_q    <= byte_data_i;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (wrap) begin
            tx_q    <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (wrap) begin
            if (byte_valid_i) begin
              sh_q    <= byte_data_i;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: 32-bit words in over valid/ready, out as 8N1 bytes MSB-first.
// Ports: clk, rst (sync, active-low), s_valid/s_data/s_ready, tx, busy,
//   words_sent. Build option: UART_SYNC_HEADER_EN prefixes 0xA5.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_word_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  // Word-level FSM: DATA spans the whole byte sequence,
  // bit-level timing lives in the byte serialiser.
  state_e           state_q;
  logic [2:0]       idx_q;
  logic [31:0]      word_q;
  logic             s_ready_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic       accept;
  logic       last;
  logic       byte_valid;
  logic       byte_done;
  logic [7:0] byte_data;

  assign accept     = s_valid && s_ready_q;
  assign last       = (idx_q == LAST_IDX);
  assign byte_valid = accept || (byte_done && !last);

  // The first byte bypasses word_q so tx can fall on the accept edge.
`ifdef UART_SYNC_HEADER_EN
  assign byte_data = accept ? UART_SYNC_BYTE : word_q[31:24];
`else
  assign byte_data = accept ? s_data[31:24] : word_q[31:24];
`endif

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign words_sent = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            idx_q     <= '0;
`ifdef UART_SYNC_HEADER_EN
            word_q    <= s_data;
`else
            word_q    <= {s_data[23:0], 8'h00};
`endif
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (byte_done) begin
            if (last) begin
              state_q <= DONE;
            end else begin
              idx_q  <= idx_q + 1'b1;
              word_q <= {word_q[23:0], 8'h00};
            end
          end
        end
        DONE: begin
          cnt_q     <= cnt_q + 1'b1;
          busy_q    <= 1'b0;
          s_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_done_o (byte_done),
    .tx_o        (tx)
  );

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Downstream stage of the TRNG/PicoRV32 output FIFO. It takes 32-bit random words over a valid/ready handshake and serialises each word as four 8N1 UART bytes on a single TX line to the STM32 host. Bytes go out most-significant first. The block is fully synchronous to the system clock.

Parameters:
CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200); must be >= 2, enforced by an elaboration-time check.
CNT_W, 16, width of the words_sent counter.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous reset, active-low (rst=0 resets on the next clk rising edge)
s_valid  input  1  upstream word valid (FIFO not empty)
s_data  input  32  upstream word; sampled only on handshake
s_ready  output  1  block can accept a word
tx  output  1  UART serial line; idle high
busy  output  1  word transmission in progress
words_sent  output  CNT_W  count of fully transmitted words

Behaviour:
- Reset values (while rst=0): tx=1, s_ready=0, busy=0, words_sent=0, state=IDLE, all counters 0.
- Handshake:
  - A word is accepted on a clk edge where s_valid=1 and s_ready=1.
  - s_ready=1 only in IDLE. It is registered and drops on the cycle after acceptance.
  - s_data is latched into a 32-bit shift register at acceptance. It is ignored at all other times.
- State machine:
  - IDLE -> START on accept. Also sets byte_idx=0 and busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<3: byte_idx++ and go to START; else go to DONE.
  - DONE: one cycle. words_sent++, busy=0, s_ready=1 -> IDLE.
- Byte order: s_data[31:24], [23:16], [15:8], [7:0].
- Latency and timing:
  - tx falls on the first edge after acceptance (tx is registered).
  - Word duration is exactly 40*CLKS_PER_BIT cycles from the tx fall to the end of the last stop bit, plus 1 DONE cycle.
  - Back-to-back words with s_valid held high: acceptance happens in the IDLE cycle, so there are exactly 2 cycles of idle-high tx between the last stop bit and the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Bit transitions happen only at the wrap.
- words_sent wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset mid-transmission: the in-flight word is discarded. tx returns to 1 on the reset edge and words_sent clears. No partial-byte completion.
- s_valid dropping after acceptance has no effect. s_valid toggling while busy is ignored.
- tx is glitch-free, driven directly from a flop.

Optional Feature:
- Macro: UART_SYNC_HEADER_EN.
- When defined: each word is preceded by the sync byte 0xA5, giving a 5-byte frame. Order is 0xA5, then [31:24]..[7:0]. Word duration becomes 50*CLKS_PER_BIT cycles, and byte_idx counts 0..4.
- When undefined: 4-byte frame as specified above, and no header logic is present.

Decomposition:
- Package uart_pkg contains:
  - state enum (IDLE, START, DATA, STOP, DONE)
  - UART_SYNC_BYTE = 8'hA5
  - BITS_PER_BYTE = 8
  - BYTES_PER_WORD = 4
- Sub-module uart_byte_tx: byte serialiser with start/data/stop sequencing and the baud counter, using a byte_valid/byte_done handshake.
- uart_word_tx holds the word latch, byte sequencing, handshake and counter.

Test Plan:
Use CLKS_PER_BIT=4 for all scenarios.
- Reset check: hold rst=0 for 5 cycles, then release -> tx=1, busy=0, words_sent=0; s_ready=1 one cycle after release.
- Single word: s_data=0xDEADBEEF pulsed with s_valid for 1 cycle -> decoded bytes DE, AD, BE, EF with each start bit 0, LSB first, and stop bit 1. Duration 160 cycles, then words_sent=1.
- Back-to-back: s_valid held for words 0x01234567 and 0x89ABCDEF -> 2 idle-high cycles between frames; words_sent=2; exactly two handshakes.
- Ignored input: change s_data and toggle s_valid during transmission -> transmitted bytes unchanged; no extra acceptance.
- Reset mid-frame: assert rst=0 during byte 2's DATA state -> tx=1 on the next edge, words_sent=0; a new word is accepted cleanly after release.
- Wrap (CNT_W=2): send 5 words -> words_sent sequence 1, 2, 3, 0, 1. With UART_SYNC_HEADER_EN defined, each frame starts with 0xA5 and lasts 200 cycles.
